// File: rtl/m_proc_pipe.sv
// Four-stage RV32 add/sub/addi pipeline (IF, ID, EX, WB). Hazards are resolved
// by EX forwarding (FWD=1) or a one-cycle interlock (FWD=0); a write to x30 halts.
module m_proc_pipe #(
  parameter int XLEN    = 32,
  parameter int FWD     = 1,
  parameter int PC_STEP = 4
) (
  input  logic            w_clk,
  input  logic            w_rst,
  output logic [XLEN-1:0] w_pc,
  input  logic [31:0]     w_ir,
  output logic            w_wb_we,
  output logic [4:0]      w_wb_wa,
  output logic [XLEN-1:0] w_wb_wd,
  output logic            w_halt
);

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ADDI, OP_NONE} op_e;

  logic [XLEN-1:0] pc_q;
  logic            halt_q;
  logic [XLEN-1:0] rf [32];

  logic            ifid_valid;
  logic [31:0]     ifid_ir;

  logic            idex_valid;
  op_e             idex_op;
  logic [4:0]      idex_rd, idex_rs1, idex_rs2;
  logic [XLEN-1:0] idex_a, idex_b;

  logic            exwb_valid;
  logic [4:0]      exwb_rd;
  logic [XLEN-1:0] exwb_wd;

  // ID stage signals
  op_e             id_op;
  logic            id_legal, id_uses_rs2, stall;
  logic [4:0]      id_rd, id_rs1, id_rs2;
  logic [XLEN-1:0] id_imm, id_rs1_val, id_rs2_val;

  // EX stage signals
  logic            fwd_a, fwd_b;
  logic [XLEN-1:0] ex_a, ex_b, ex_res;

  assign w_pc    = pc_q;
  assign w_halt  = halt_q;
  assign w_wb_we = exwb_valid && (exwb_rd != 5'd0) && !halt_q && !w_rst;
  assign w_wb_wa = exwb_rd;
  assign w_wb_wd = exwb_wd;

  assign id_rd  = ifid_ir[11:7];
  assign id_rs1 = ifid_ir[19:15];
  assign id_rs2 = ifid_ir[24:20];
  assign id_imm = {{(XLEN-12){ifid_ir[31]}}, ifid_ir[31:20]};

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    id_op = OP_NONE;
    if (ifid_ir[6:0] == 7'b0110011 && ifid_ir[14:12] == 3'b000) begin
      if (ifid_ir[31:25] == 7'b0000000)      id_op = OP_ADD;
      else if (ifid_ir[31:25] == 7'b0100000) id_op = OP_SUB;
    end else if (ifid_ir[6:0] == 7'b0010011 && ifid_ir[14:12] == 3'b000) begin
      id_op = OP_ADDI;
    end
  end

  assign id_legal    = ifid_valid && (id_op != OP_NONE);
  assign id_uses_rs2 = (id_op == OP_ADD) || (id_op == OP_SUB);

  // Write-through: a same-cycle retirement is visible to the ID read.
  assign id_rs1_val = (id_rs1 == 5'd0) ? '0 :
                      (w_wb_we && w_wb_wa == id_rs1) ? w_wb_wd : rf[id_rs1];
  assign id_rs2_val = (id_rs2 == 5'd0) ? '0 :
                      (w_wb_we && w_wb_wa == id_rs2) ? w_wb_wd : rf[id_rs2];

  assign stall = (FWD == 0) && id_legal && idex_valid && (idex_rd != 5'd0) &&
                 ((id_rs1 == idex_rd) || (id_uses_rs2 && id_rs2 == idex_rd));

  assign fwd_a = (FWD != 0) && exwb_valid && (exwb_rd != 5'd0) && (exwb_rd == idex_rs1);
  assign fwd_b = (FWD != 0) && exwb_valid && (exwb_rd != 5'd0) && (exwb_rd == idex_rs2) &&
                 (idex_op != OP_ADDI);
  assign ex_a   = fwd_a ? exwb_wd : idex_a;
  assign ex_b   = fwd_b ? exwb_wd : idex_b;
  assign ex_res = (idex_op == OP_SUB) ? (ex_a - ex_b) : (ex_a + ex_b);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      pc_q       <= '0;
      halt_q     <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_ir    <= '0;
      idex_valid <= 1'b0;
      idex_op    <= OP_NONE;
      idex_rd    <= '0;
      idex_rs1   <= '0;
      idex_rs2   <= '0;
      idex_a     <= '0;
      idex_b     <= '0;
      exwb_valid <= 1'b0;
      exwb_rd    <= '0;
      exwb_wd    <= '0;
      // NOTE: the register file is cleared on reset, so it cannot map to a plain RAM macro.
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!halt_q) begin
      if (w_wb_we) rf[w_wb_wa] <= w_wb_wd;
      if (w_wb_we && w_wb_wa == 5'd30) halt_q <= 1'b1;

      exwb_valid <= idex_valid;
      exwb_rd    <= idex_rd;
      exwb_wd    <= ex_res;

      if (stall) begin
        idex_valid <= 1'b0;
      end else begin
        idex_valid <= id_legal;
        idex_op    <= id_op;
        idex_rd    <= id_rd;
        idex_rs1   <= id_rs1;
        idex_rs2   <= id_rs2;
        idex_a     <= id_rs1_val;
        idex_b     <= (id_op == OP_ADDI) ? id_imm : id_rs2_val;

        pc_q       <= pc_q + XLEN'(PC_STEP);
        ifid_valid <= 1'b1;
        ifid_ir    <= w_ir;
      end
    end
  end

endmodule

// File: tb/tb_m_proc_pipe.sv
// Scoreboard bench: runs forwarding and interlock builds side by side on the
// same directed programs and checks every retirement against hand-computed values.
module tb_m_proc_pipe;

  localparam int XLEN = 32;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    int          cyc;
  } exp_t;

  logic            w_clk = 1'b0;
  logic            w_rst = 1'b1;
  logic [XLEN-1:0] pc_f, pc_s, wd_f, wd_s;
  logic [31:0]     ir_f, ir_s;
  logic            we_f, we_s, halt_f, halt_s;
  logic [4:0]      wa_f, wa_s;
  logic [31:0]     imem [64];

  exp_t q_f[$];
  exp_t q_s[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  assign ir_f = imem[pc_f[7:2]];
  assign ir_s = imem[pc_s[7:2]];

  m_proc_pipe #(.XLEN(XLEN), .FWD(1), .PC_STEP(4)) u_fwd (
    .w_clk(w_clk), .w_rst(w_rst), .w_pc(pc_f), .w_ir(ir_f),
    .w_wb_we(we_f), .w_wb_wa(wa_f), .w_wb_wd(wd_f), .w_halt(halt_f)
  );

  m_proc_pipe #(.XLEN(XLEN), .FWD(0), .PC_STEP(4)) u_stl (
    .w_clk(w_clk), .w_rst(w_rst), .w_pc(pc_s), .w_ir(ir_s),
    .w_wb_we(we_s), .w_wb_wa(wa_s), .w_wb_wd(wd_s), .w_halt(halt_s)
  );

  always #5 w_clk = ~w_clk;

  // Cycle 0 is the first cycle after the last reset edge.
  always @(posedge w_clk) begin
    if (w_rst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_errors++;
    $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) fail(name, act, exp);
  endtask

  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    logic [11:0] i12;
    logic [4:0]  d, s;
    i12 = imm[11:0];
    d   = rd[4:0];
    s   = rs1[4:0];
    return {i12, s, 3'b000, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
    logic [4:0] d, s1, s2;
    d  = rd[4:0];
    s1 = rs1[4:0];
    s2 = rs2[4:0];
    return {f7, s2, s1, 3'b000, d, 7'b0110011};
  endfunction

  task automatic push2(input int wa, input logic [31:0] wd, input int cf, input int cs);
    exp_t e;
    e.wa  = wa[4:0];
    e.wd  = wd;
    e.cyc = cf;
    q_f.push_back(e);
    e.cyc = cs;
    q_s.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge w_clk);
      if (we_f) begin
        if (q_f.size() == 0) fail("fwd_unexpected_retire", {59'd0, wa_f}, 64'd0);
        else begin
          e = q_f.pop_front();
          check("fwd_wa", wa_f, e.wa);
          check("fwd_wd", wd_f, e.wd);
          check("fwd_cyc", cyc, e.cyc);
        end
      end
      if (we_s) begin
        if (q_s.size() == 0) fail("stl_unexpected_retire", {59'd0, wa_s}, 64'd0);
        else begin
          e = q_s.pop_front();
          check("stl_wa", wa_s, e.wa);
          check("stl_wd", wd_s, e.wd);
          check("stl_cyc", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic reset_start();
    @(posedge w_clk);
    #1 w_rst = 1'b1;
    @(posedge w_clk);
    #1;
    check("rst_pc_f", pc_f, 0);   check("rst_pc_s", pc_s, 0);
    check("rst_we_f", we_f, 0);   check("rst_we_s", we_s, 0);
    check("rst_wa_f", wa_f, 0);   check("rst_wa_s", wa_s, 0);
    check("rst_wd_f", wd_f, 0);   check("rst_wd_s", wd_s, 0);
    check("rst_halt_f", halt_f, 0); check("rst_halt_s", halt_s, 0);
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic reset_end();
    @(posedge w_clk);
    #1 w_rst = 1'b0;
  endtask

  task automatic run_test(input int t);
    for (int c = 0; c < 14; c++) begin
      @(negedge w_clk);
      case (t)
        1: begin
          if (c <= 3) begin
            check($sformatf("p1_pc_f_c%0d", c), pc_f, 4 * c);
            check($sformatf("p1_pc_s_c%0d", c), pc_s, 4 * c);
          end
          if (c == 4) begin
            check("p1_pc_f_c4", pc_f, 16);
            check("p1_pc_s_hold_c4", pc_s, 12);
          end
          if (c == 5) check("p1_pc_s_c5", pc_s, 16);
        end
        2: begin
          if (c == 6) check("p2_pc_s_c6", pc_s, 20);
          if (c == 7) check("p2_pc_s_hold_c7", pc_s, 20);
          if (c == 8) check("p2_pc_s_c8", pc_s, 24);
          if (c == 8) check("p2_pc_f_c8", pc_f, 32);
        end
        4: begin
          if (c == 3) begin
            check("p4_halt_f_c3", halt_f, 0);
            check("p4_halt_s_c3", halt_s, 0);
          end
          if (c == 4 || c == 10) begin
            check($sformatf("p4_halt_f_c%0d", c), halt_f, 1);
            check($sformatf("p4_halt_s_c%0d", c), halt_s, 1);
            check($sformatf("p4_pc_f_frozen_c%0d", c), pc_f, 16);
            check($sformatf("p4_pc_s_frozen_c%0d", c), pc_s, 16);
          end
        end
        5: begin
          if (c <= 1) begin
            check($sformatf("p5_pc_f_c%0d", c), pc_f, 4 * c);
            check($sformatf("p5_pc_s_c%0d", c), pc_s, 4 * c);
          end
          if (c == 4) begin
            check("p5_halt_f_c4", halt_f, 1);
            check("p5_halt_s_c4", halt_s, 1);
          end
        end
        default: ;
      endcase
    end
    check($sformatf("drain_f_t%0d", t), q_f.size(), 0);
    check($sformatf("drain_s_t%0d", t), q_s.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    fork
      monitor();
    join_none

    // Dependent add: distance-1 and distance-2 producers.
    reset_start();
    imem[0] = enc_addi(1, 0, 5);
    imem[1] = enc_addi(2, 0, 6);
    imem[2] = enc_r(7'b0000000, 5, 1, 2);
    push2(1, 32'd5, 3, 3);
    push2(2, 32'd6, 4, 4);
    push2(5, 32'd11, 5, 6);
    reset_end();
    run_test(1);

    // Wrapping sub, negative immediate, rs1 hazard on addi.
    reset_start();
    imem[0] = enc_addi(3, 0, 7);
    imem[1] = enc_addi(4, 0, 8);
    imem[2] = enc_r(7'b0100000, 6, 3, 4);
    imem[3] = enc_addi(9, 0, -1);
    imem[4] = enc_addi(10, 9, 2);
    push2(3, 32'd7, 3, 3);
    push2(4, 32'd8, 4, 4);
    push2(6, 32'hFFFF_FFFF, 5, 6);
    push2(9, 32'hFFFF_FFFF, 6, 7);
    push2(10, 32'd1, 7, 9);
    reset_end();
    run_test(2);

    // x0 destination, x0 sources, all-zero word and an unsupported R-type.
    reset_start();
    imem[0] = enc_addi(0, 0, 9);
    imem[1] = enc_r(7'b0000000, 7, 0, 0);
    imem[2] = 32'h0000_0000;
    imem[3] = 32'h0020_1633;
    push2(7, 32'd0, 4, 4);
    reset_end();
    run_test(3);

    // Halt on x30; the younger addi must never retire.
    reset_start();
    imem[0] = enc_addi(30, 0, 1);
    imem[1] = enc_addi(8, 0, 3);
    push2(30, 32'd1, 3, 3);
    reset_end();
    run_test(4);

    // Reset while halted restarts from pc 0.
    reset_start();
    imem[0] = enc_addi(30, 0, 1);
    imem[1] = enc_addi(8, 0, 3);
    push2(30, 32'd1, 3, 3);
    reset_end();
    run_test(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
